// File: rtl/snn_pkg.sv
// Shared types and constants for the spiking-neuron layer sequencer and its neuron cell.
package snn_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        ACCUM  = 3'd2,
        DRAIN  = 3'd3,
        DECAY  = 3'd4,
        OUTPUT = 3'd5
    } state_t;

    localparam logic FUNC_ADD   = 1'b0;
    localparam logic FUNC_DECAY = 1'b1;

endpackage

// File: rtl/neuron.sv
// Combinational neuron cell: wrapping add of a weight (spike = carry out), or
// multiplicative decay by a Q0.SIZE beta (spike = strict threshold crossing).
module neuron
    import snn_pkg::*;
#(
    parameter int SIZE = 8
) (
    input  logic            function_sel,
    input  logic [SIZE-1:0] v_mem_in,
    input  logic [SIZE-1:0] weight,
    input  logic [SIZE-1:0] beta,
    input  logic [SIZE-1:0] v_th,
    output logic [SIZE-1:0] v_mem_out,
    output logic            spike
);

    logic [SIZE:0]     sum;
    logic [2*SIZE-1:0] prod;
    logic [SIZE-1:0]   decayed;

    assign sum     = {1'b0, v_mem_in} + {1'b0, weight};
    assign prod    = {{SIZE{1'b0}}, v_mem_in} * {{SIZE{1'b0}}, beta};
    assign decayed = prod[2*SIZE-1:SIZE];

    always_comb begin
        v_mem_out = sum[SIZE-1:0];
        spike     = sum[SIZE];
        if (function_sel == FUNC_DECAY) begin
            v_mem_out = decayed;
            spike     = (decayed > v_th);
        end
    end

endmodule

// File: rtl/neuron_layer_ctrl.sv
// Time-multiplexes one neuron cell over a fully connected SNN layer: accumulates
// weighted input spikes per neuron, then decays/fires, and hands the spike vector on.
module neuron_layer_ctrl
    import snn_pkg::*;
#(
    parameter int SIZE        = 8,
    parameter int NUM_INPUTS  = 16,
    parameter int NUM_NEURONS = 16,
    parameter int WADDR_W     = $clog2(NUM_NEURONS*NUM_INPUTS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   clear_vmem,
    input  logic [NUM_INPUTS-1:0]  in_spikes,
    input  logic [SIZE-1:0]        beta,
    input  logic [SIZE-1:0]        v_th,
    output logic                   w_rd_en,
    output logic [WADDR_W-1:0]     w_addr,
    input  logic [SIZE-1:0]        w_rdata,
    output logic                   busy,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NUM_NEURONS-1:0] out_spikes,
    output logic                   done
);

    localparam int NW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam int IW = $clog2(NUM_INPUTS);

    state_t state_q, state_d;

    logic [NUM_INPUTS-1:0]  spk_q, spk_d;
    logic [NW-1:0]          n_q, n_d;
    logic [IW-1:0]          i_q, i_d;
    logic [SIZE-1:0]        acc_q, acc_d;
    logic                   ovf_q, ovf_d;
    logic                   pend_q, pend_d;
    logic [NUM_NEURONS-1:0] out_spikes_q, out_spikes_d;
    logic [SIZE-1:0]        vmem_q [NUM_NEURONS];
    logic [SIZE-1:0]        vmem_d [NUM_NEURONS];

    logic            last_input;
    logic            last_neuron;
    logic            fired;
    logic            nrn_func;
    logic [SIZE-1:0] nrn_weight;
    logic [SIZE-1:0] nrn_out;
    logic            nrn_spike;

    assign last_input  = (i_q == IW'(NUM_INPUTS - 1));
    assign last_neuron = (n_q == NW'(NUM_NEURONS - 1));

    neuron #(
        .SIZE(SIZE)
    ) u_neuron (
        .function_sel(nrn_func),
        .v_mem_in    (acc_q),
        .weight      (nrn_weight),
        .beta        (beta),
        .v_th        (v_th),
        .v_mem_out   (nrn_out),
        .spike       (nrn_spike)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = LOAD;
            LOAD:    state_d = ACCUM;
            ACCUM:   if (last_input) state_d = DRAIN;
            DRAIN:   state_d = DECAY;
            DECAY:   state_d = last_neuron ? OUTPUT : LOAD;
            OUTPUT:  if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Address is forced to zero whenever no read is issued so the bus is quiet when idle.
    always_comb begin
        busy      = (state_q != IDLE);
        out_valid = (state_q == OUTPUT);
        done      = (state_q == OUTPUT) && out_ready;
        w_rd_en   = (state_q == ACCUM) && spk_q[i_q];
        w_addr    = '0;
        if (w_rd_en) begin
            w_addr = WADDR_W'(n_q) * WADDR_W'(NUM_INPUTS) + WADDR_W'(i_q);
        end
    end

    assign out_spikes = out_spikes_q;

    always_comb begin
        spk_d        = spk_q;
        n_d          = n_q;
        i_d          = i_q;
        acc_d        = acc_q;
        ovf_d        = ovf_q;
        pend_d       = w_rd_en;
        out_spikes_d = out_spikes_q;
        vmem_d       = vmem_q;
        nrn_func     = FUNC_ADD;
        nrn_weight   = w_rdata;
        fired        = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    spk_d        = in_spikes;
                    n_d          = '0;
                    out_spikes_d = '0;
                end else if (clear_vmem) begin
                    for (int k = 0; k < NUM_NEURONS; k++) begin
                        vmem_d[k] = '0;
                    end
                end
            end
            LOAD: begin
                acc_d = vmem_q[n_q];
                i_d   = '0;
                ovf_d = 1'b0;
            end
            ACCUM, DRAIN: begin
                // Weight data lags its read strobe by one cycle; retire it into acc now.
                if (pend_q) begin
                    acc_d = nrn_out;
                    ovf_d = ovf_q | nrn_spike;
                end
                if (state_q == ACCUM && !last_input) begin
                    i_d = i_q + IW'(1);
                end
            end
            DECAY: begin
                nrn_func   = FUNC_DECAY;
                nrn_weight = '0;
                fired      = nrn_spike | ovf_q;
                vmem_d[n_q]       = fired ? '0 : nrn_out;
                out_spikes_d[n_q] = fired;
                if (!last_neuron) begin
                    n_d = n_q + NW'(1);
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spk_q        <= '0;
            n_q          <= '0;
            i_q          <= '0;
            acc_q        <= '0;
            ovf_q        <= 1'b0;
            pend_q       <= 1'b0;
            out_spikes_q <= '0;
            for (int k = 0; k < NUM_NEURONS; k++) begin
                vmem_q[k] <= '0;
            end
        end else begin
            spk_q        <= spk_d;
            n_q          <= n_d;
            i_q          <= i_d;
            acc_q        <= acc_d;
            ovf_q        <= ovf_d;
            pend_q       <= pend_d;
            out_spikes_q <= out_spikes_d;
            for (int k = 0; k < NUM_NEURONS; k++) begin
                vmem_q[k] <= vmem_d[k];
            end
        end
    end

endmodule

// File: tb/tb_neuron_layer_ctrl.sv
// Randomized scoreboard bench for neuron_layer_ctrl against a behavioural layer model.
module tb_neuron_layer_ctrl;

    localparam int SIZE = 8;
    localparam int NI   = 4;
    localparam int NN   = 2;
    localparam int AW   = 3;
    localparam int LAT  = NN * (NI + 3);

    typedef struct {
        logic [NN-1:0]    spikes;
        logic [NN*NI-1:0] mask;
        int               reads;
    } exp_t;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic            clear_vmem;
    logic [NI-1:0]   in_spikes;
    logic [SIZE-1:0] beta;
    logic [SIZE-1:0] v_th;
    logic            w_rd_en;
    logic [AW-1:0]   w_addr;
    logic [SIZE-1:0] w_rdata;
    logic            busy;
    logic            out_valid;
    logic            out_ready;
    logic [NN-1:0]   out_spikes;
    logic            done;

    int   total;
    int   bad;
    int   wmem   [NN*NI];
    int   mvmem  [NN];
    exp_t sbq    [$];

    neuron_layer_ctrl #(
        .SIZE       (SIZE),
        .NUM_INPUTS (NI),
        .NUM_NEURONS(NN),
        .WADDR_W    (AW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .clear_vmem(clear_vmem),
        .in_spikes (in_spikes),
        .beta      (beta),
        .v_th      (v_th),
        .w_rd_en   (w_rd_en),
        .w_addr    (w_addr),
        .w_rdata   (w_rdata),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_spikes(out_spikes),
        .done      (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Weight memory with one cycle of read latency; garbage on the bus when not reading.
    always @(posedge clk) begin
        if (w_rd_en) w_rdata <= 8'(wmem[w_addr]);
        else         w_rdata <= 8'($urandom);
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Layer behaviour: per neuron, sum weights of active inputs mod 256 (any wrap forces
    // a spike), decay by beta/256, fire if above threshold, then reset or keep membrane.
    task automatic modelStep(input logic [NI-1:0] spk, output exp_t e);
        int  acc;
        int  s;
        int  dec;
        bit  ovf;
        bit  fired;
        e.spikes = '0;
        e.mask   = '0;
        e.reads  = 0;
        for (int n = 0; n < NN; n++) begin
            acc = mvmem[n];
            ovf = 1'b0;
            for (int i = 0; i < NI; i++) begin
                if (spk[i]) begin
                    s = acc + wmem[n*NI + i];
                    if (s > 255) ovf = 1'b1;
                    acc = s % 256;
                    e.mask[n*NI + i] = 1'b1;
                    e.reads++;
                end
            end
            dec      = (acc * int'(beta)) / 256;
            fired    = ovf || (dec > int'(v_th));
            mvmem[n] = fired ? 0 : dec;
            e.spikes[n] = fired;
        end
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        sbq.delete();
        for (int n = 0; n < NN; n++) mvmem[n] = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
    endtask

    task automatic applyClear();
        clear_vmem = 1'b1;
        @(posedge clk);
        #1;
        clear_vmem = 1'b0;
        for (int n = 0; n < NN; n++) mvmem[n] = 0;
    endtask

    task automatic applyStimulus(input logic [NI-1:0] spk, input int bp, input int abort_at,
                                 input bit with_clear);
        exp_t e;
        int   stall;
        bit   ready_given;
        bit   finished;
        modelStep(spk, e);
        sbq.push_back(e);
        start      = 1'b1;
        clear_vmem = with_clear;
        in_spikes  = spk;
        @(posedge clk);
        #1;
        start      = 1'b0;
        clear_vmem = 1'b0;
        in_spikes  = 4'($urandom);
        if (abort_at > 0) begin
            repeat (abort_at) begin
                @(posedge clk);
                #1;
                in_spikes = 4'($urandom);
            end
            applyReset();
            return;
        end
        stall       = bp;
        ready_given = 1'b0;
        finished    = 1'b0;
        for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
            @(posedge clk);
            #1;
            if (ready_given) begin
                finished = 1'b1;
            end else begin
                start      = ($urandom_range(0, 5) == 0);
                clear_vmem = ($urandom_range(0, 5) == 0);
                in_spikes  = 4'($urandom);
                if (out_valid) begin
                    if (stall > 0) begin
                        stall--;
                        out_ready = 1'b0;
                    end else begin
                        out_ready   = 1'b1;
                        ready_given = 1'b1;
                    end
                end else begin
                    out_ready = 1'($urandom);
                end
            end
        end
        start      = 1'b0;
        clear_vmem = 1'b0;
        out_ready  = 1'b0;
        if (!finished) begin
            checkOutput("handshake_timeout", 0, 1);
            applyReset();
        end
    endtask

    // Monitor: observes the DUT on the falling edge and retires scoreboard entries on handshake.
    int            lat;
    int            reads;
    logic [NN*NI-1:0] mask;
    bit            seen_valid;
    bit            was_busy;
    bit            hs_prev;
    logic [NN-1:0] last_exp;

    always @(negedge clk) begin
        if (!rst_n) begin
            checkOutput("reset_outputs",
                        int'({busy, out_valid, done, w_rd_en, w_addr, out_spikes}), 0);
            was_busy   = 1'b0;
            hs_prev    = 1'b0;
            seen_valid = 1'b0;
            last_exp   = '0;
        end else begin
            if (hs_prev) checkOutput("idle_after_handshake", int'({busy, out_valid}), 0);
            hs_prev = 1'b0;
            if (busy && !was_busy) begin
                lat        = 0;
                reads      = 0;
                mask       = '0;
                seen_valid = 1'b0;
            end else if (busy) begin
                lat++;
            end
            if (w_rd_en) begin
                mask[w_addr] = 1'b1;
                reads++;
            end
            if (!busy) begin
                checkOutput("idle_quiet", int'({w_rd_en, done, out_valid}), 0);
                checkOutput("spikes_hold", int'(out_spikes), int'(last_exp));
            end
            if (out_valid) begin
                if (sbq.size() == 0) begin
                    checkOutput("unexpected_valid", 1, 0);
                end else begin
                    if (!seen_valid) begin
                        seen_valid = 1'b1;
                        checkOutput("latency", lat, LAT);
                    end
                    checkOutput("out_spikes", int'(out_spikes), int'(sbq[0].spikes));
                    if (out_ready) begin
                        checkOutput("done_on_handshake", int'(done), 1);
                        checkOutput("read_addresses", int'(mask), int'(sbq[0].mask));
                        checkOutput("read_count", reads, sbq[0].reads);
                        last_exp = sbq[0].spikes;
                        void'(sbq.pop_front());
                        hs_prev = 1'b1;
                    end else begin
                        checkOutput("done_while_stalled", int'(done), 0);
                    end
                end
            end else begin
                checkOutput("done_without_valid", int'(done), 0);
            end
            was_busy = busy;
        end
    end

    initial begin
        total      = 0;
        bad        = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        clear_vmem = 1'b0;
        in_spikes  = '0;
        out_ready  = 1'b0;
        beta       = 8'd128;
        v_th       = 8'd50;
        for (int n = 0; n < NN; n++) mvmem[n] = 0;
        wmem = '{40, 77, 30, 91, 200, 100, 0, 0};
        applyReset();

        $display("[TB] mid-run reset then fresh timestep");
        applyStimulus(4'b1111, 0, 6, 1'b0);
        applyStimulus(4'b0101, 0, 0, 1'b0);

        $display("[TB] accumulate / threshold / overflow / no-input");
        applyReset();
        applyStimulus(4'b0101, 0, 0, 1'b0);
        applyStimulus(4'b0101, 0, 0, 1'b0);
        applyStimulus(4'b0011, 0, 0, 1'b0);
        applyClear();
        applyStimulus(4'b0101, 0, 0, 1'b0);
        applyStimulus(4'b0000, 0, 0, 1'b0);

        $display("[TB] backpressure, clear with start, threshold equality");
        applyStimulus(4'b1010, 10, 0, 1'b0);
        applyStimulus(4'b0101, 3, 0, 1'b1);
        applyClear();
        v_th = 8'd35;
        applyStimulus(4'b0101, 0, 0, 1'b0);
        v_th = 8'd50;

        $display("[TB] randomized timesteps");
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                for (int a = 0; a < NN*NI; a++) wmem[a] = int'($urandom_range(0, 255));
            end
            beta = 8'($urandom);
            v_th = 8'($urandom_range(0, 120));
            if ($urandom_range(0, 5) == 0) applyClear();
            applyStimulus(4'($urandom), int'($urandom_range(0, 4)),
                          ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 12)) : 0,
                          ($urandom_range(0, 5) == 0));
        end

        repeat (3) @(posedge clk);
        checkOutput("scoreboard_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
